multiplexador_arbitrado: RTL and testbench
==========================================

MULTIPLEXADOR_ARBITRADO -- requirements
Module: multiplexador_arbitrado

Interface
REQ-001 Parameter LARGURA, default 16, data word width in bits.
REQ-002 Parameter CANAIS, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(CANAIS), selector/channel-index width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 entrada  input  CANAIS*LARGURA  packed channel words; channel i occupies bits [i*LARGURA +: LARGURA].
REQ-007 entrada_valida  input  CANAIS  per-channel word-valid.
REQ-008 entrada_pronta  output  CANAIS  per-channel accept strobe; at most one bit high per cycle.
REQ-009 M  input  SEL_W  fixed channel select, used when modo=0.
REQ-010 modo  input  1  0 = fixed select by M; 1 = round-robin arbitration.
REQ-011 resultado  output  LARGURA  registered selected word.
REQ-012 resultado_valido  output  1  resultado holds a word.
REQ-013 resultado_pronto  input  1  downstream accepts resultado.
REQ-014 canal  output  SEL_W  index of the channel that produced resultado.

Function
REQ-015 Two-state FSM: VAZIO (output register empty), CHEIO (output register full); resultado_valido = (state==CHEIO).
REQ-016 Load condition "carga" = state==VAZIO, or state==CHEIO with resultado_pronto=1 (same-cycle drain and refill).
REQ-017 Grant, modo=0: channel M granted when carga=1, M<CANAIS and entrada_valida[M]=1; otherwise no grant.
REQ-018 Grant, modo=1: first channel with entrada_valida=1 searched from ponteiro upward, wrapping CANAIS-1 to 0; no grant if none valid.
REQ-019 entrada_pronta[g]=1 combinationally only in the cycle channel g is granted; all other bits 0.
REQ-020 On grant, the next edge loads resultado<=entrada[g], canal<=g, state<=CHEIO.
REQ-021 When carga=1 and no grant: if resultado_pronto=1 or state==VAZIO, next state VAZIO; resultado/canal retain last values.
REQ-022 In CHEIO with resultado_pronto=0: resultado, canal, resultado_valido held stable; entrada_pronta all 0.
REQ-023 Latency: word accepted in cycle N appears at resultado with resultado_valido=1 in cycle N+1.
REQ-024 Throughput: one word per cycle while resultado_pronto stays 1 and a grant exists each cycle.
REQ-025 ponteiro (SEL_W bits) advances to (g+1) mod CANAIS on every modo=1 grant; unchanged on modo=0 grants or no grant.
REQ-026 modo or M changes take effect at the next grant decision; a held word is unaffected.
REQ-027 Input words not granted are not consumed; holding them is the sender's responsibility.

Reset
REQ-028 reset_n=0 asynchronously forces state=VAZIO, resultado=0, canal=0, ponteiro=0, resultado_valido=0.
REQ-029 While reset_n=0, entrada_pronta=0 regardless of inputs.
REQ-030 Reset asserted mid-transfer discards the held word; after release, first grant follows REQ-017/018 with ponteiro=0.

Verification
REQ-031 modo=0, M=2, entrada_valida=4'b0100, entrada[2]=16'hA5A5, resultado_pronto=1 -> entrada_pronta=4'b0100 in cycle N; resultado=16'hA5A5, canal=2, resultado_valido=1 in N+1.
REQ-032 modo=1, all four channels valid continuously, resultado_pronto=1 -> canal sequence 0,1,2,3,0 on consecutive cycles, one entrada_pronta bit per cycle.
REQ-033 modo=1, valid only on channels 1 and 3, ponteiro=2 -> channel 3 granted first, then 1 (wrap).
REQ-034 CHEIO with resultado=16'h1234, resultado_pronto=0 for 3 cycles, channel 0 valid -> resultado stays 16'h1234, entrada_pronta=0; on resultado_pronto=1 channel 0 loaded next edge with no idle cycle.
REQ-035 modo=0, M=1, entrada_valida[1]=0, other channels valid -> no entrada_pronta, state goes/stays VAZIO after drain.
REQ-036 reset_n pulsed low between edges while CHEIO -> resultado_valido=0 and resultado=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/multiplexador_arbitrado_if.sv
// multiplexador_arbitrado_if: channel inputs, select controls and registered result handshake
interface multiplexador_arbitrado_if #(
  parameter int LARGURA = 16,
  parameter int CANAIS  = 4,
  parameter int SEL_W   = $clog2(CANAIS)
);
  logic [CANAIS*LARGURA-1:0] entrada;
  logic [CANAIS-1:0]         entrada_valida;
  logic [CANAIS-1:0]         entrada_pronta;
  logic [SEL_W-1:0]          M;
  logic                      modo;
  logic [LARGURA-1:0]        resultado;
  logic                      resultado_valido;
  logic                      resultado_pronto;
  logic [SEL_W-1:0]          canal;
  modport master (
    output entrada, entrada_valida, M, modo, resultado_pronto,
    input  entrada_pronta, resultado, resultado_valido, canal
  );
  modport slave (
    input  entrada, entrada_valida, M, modo, resultado_pronto,
    output entrada_pronta, resultado, resultado_valido, canal
  );
endinterface

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado: fixed-select or round-robin N:1 mux into a one-word output register
module multiplexador_arbitrado #(
  parameter int LARGURA = 16,
  parameter int CANAIS  = 4,
  parameter int SEL_W   = $clog2(CANAIS)
) (
  input logic                     clock,
  input logic                     reset_n,
  multiplexador_arbitrado_if.slave bus
);
  typedef enum logic {VAZIO, CHEIO} estado_t;
  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic [SEL_W-1:0]   canal_q, canal_d;
  logic [SEL_W-1:0]   ponteiro_q, ponteiro_d;
  logic               carga, concede;
  logic [SEL_W-1:0]   g, idx;
  assign carga = (estado_q == VAZIO) || bus.resultado_pronto;
  // Round-robin scans downward so the lowest offset from ponteiro is the last (winning) assignment
  always_comb begin
    concede = 1'b0;
    g = '0;
    idx = '0;
    if (reset_n && carga) begin
      if (!bus.modo) begin
        concede = (int'(bus.M) < CANAIS) && bus.entrada_valida[bus.M];
        g = bus.M;
      end else begin
        for (int k = CANAIS - 1; k >= 0; k--) begin
          idx = SEL_W'((int'(ponteiro_q) + k) % CANAIS);
          if (bus.entrada_valida[idx]) begin
            concede = 1'b1;
            g = idx;
          end
        end
      end
    end
  end
  assign bus.entrada_pronta = concede ? (CANAIS'(1) << g) : '0;
  always_comb begin
    estado_d = estado_q;
    resultado_d = resultado_q;
    canal_d = canal_q;
    ponteiro_d = ponteiro_q;
    if (concede) begin
      estado_d = CHEIO;
      resultado_d = bus.entrada[int'(g)*LARGURA +: LARGURA];
      canal_d = g;
      ponteiro_d = bus.modo ? SEL_W'((int'(g) + 1) % CANAIS) : ponteiro_q;
    end else if (carga) begin
      estado_d = VAZIO;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= VAZIO;
      resultado_q <= '0;
      canal_q <= '0;
      ponteiro_q <= '0;
    end else begin
      estado_q <= estado_d;
      resultado_q <= resultado_d;
      canal_q <= canal_d;
      ponteiro_q <= ponteiro_d;
    end
  end
  assign bus.resultado = resultado_q;
  assign bus.canal = canal_q;
  assign bus.resultado_valido = (estado_q == CHEIO);
endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// tb_multiplexador_arbitrado: directed and random stimulus against a behavioural model of the arbitrated mux
module tb_multiplexador_arbitrado;
  localparam int L = 16;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bit   m_cheio;
  logic [L-1:0] m_word;
  int   m_canal, m_ptr;
  bit   p_g;
  int   p_c;
  multiplexador_arbitrado_if #(.LARGURA(L), .CANAIS(N)) bus ();
  multiplexador_arbitrado #(.LARGURA(L), .CANAIS(N)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_cheio = 0; m_word = '0; m_canal = 0; m_ptr = 0;
  endtask
  task automatic m_grant(output bit gr, output int c);
    gr = 0; c = 0;
    if (m_cheio && !bus.resultado_pronto) return;
    if (!bus.modo) begin
      if (int'(bus.M) < N && bus.entrada_valida[bus.M]) begin gr = 1; c = int'(bus.M); end
    end else begin
      for (int k = 0; k < N; k++)
        if (!gr && bus.entrada_valida[(m_ptr + k) % N]) begin gr = 1; c = (m_ptr + k) % N; end
    end
  endtask
  task automatic set_word(input int c, input logic [L-1:0] w);
    bus.entrada[c*L +: L] = w;
  endtask
  task automatic ciclo();
    logic [N-1:0] exp_p;
    #1;
    m_grant(p_g, p_c);
    exp_p = p_g ? N'(1) << p_c : '0;
    chk("pronta", 32'(bus.entrada_pronta), 32'(exp_p));
    @(posedge clk);
    if (p_g) begin
      m_word = bus.entrada[p_c*L +: L];
      m_canal = p_c;
      if (bus.modo) m_ptr = (p_c + 1) % N;
      m_cheio = 1;
    end else if (!m_cheio || bus.resultado_pronto) m_cheio = 0;
    #1;
    chk("valido", 32'(bus.resultado_valido), 32'(m_cheio));
    chk("resultado", 32'(bus.resultado), 32'(m_word));
    chk("canal", 32'(bus.canal), 32'(m_canal));
    @(negedge clk);
  endtask
  initial begin
    m_reset();
    bus.entrada = '0; bus.entrada_valida = '1; bus.M = 2'd2; bus.modo = 1'b0; bus.resultado_pronto = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pronta", 32'(bus.entrada_pronta), 32'h0);
    chk("rst_valido", 32'(bus.resultado_valido), 32'h0);
    chk("rst_resultado", 32'(bus.resultado), 32'h0);
    chk("rst_canal", 32'(bus.canal), 32'h0);
    rst_n = 1'b1;
    // fixed select of channel 2
    bus.entrada_valida = 4'b0100; set_word(2, 16'hA5A5);
    #1 chk("r31_pronta", 32'(bus.entrada_pronta), 32'h4);
    ciclo();
    chk("r31_res", 32'(bus.resultado), 32'hA5A5);
    chk("r31_canal", 32'(bus.canal), 32'd2);
    chk("r31_valido", 32'(bus.resultado_valido), 32'd1);
    // round-robin over four valid channels, pointer starts at 0
    bus.modo = 1'b1; bus.entrada_valida = 4'b1111;
    for (int i = 0; i < N; i++) set_word(i, 16'h1000 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      ciclo();
      chk("r32_canal", 32'(bus.canal), 32'(i % N));
    end
    // pointer is 1 here; one grant on channel 1 moves it to 2
    bus.entrada_valida = 4'b0010;
    ciclo();
    bus.entrada_valida = 4'b1010;
    ciclo();
    chk("r33_first", 32'(bus.canal), 32'd3);
    ciclo();
    chk("r33_wrap", 32'(bus.canal), 32'd1);
    // stall with a held word
    bus.modo = 1'b0; bus.M = 2'd0; bus.entrada_valida = 4'b0001; set_word(0, 16'h1234);
    ciclo();
    bus.resultado_pronto = 1'b0; set_word(0, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      ciclo();
      chk("r34_hold", 32'(bus.resultado), 32'h1234);
    end
    bus.resultado_pronto = 1'b1;
    ciclo();
    chk("r34_reload", 32'(bus.resultado), 32'hBEEF);
    chk("r34_valido", 32'(bus.resultado_valido), 32'd1);
    // fixed select on an idle channel drains to empty
    bus.M = 2'd1; bus.entrada_valida = 4'b1101;
    ciclo();
    ciclo();
    chk("r35_valido", 32'(bus.resultado_valido), 32'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.modo = 1'($urandom);
      bus.M = 2'($urandom);
      bus.entrada_valida = 4'($urandom);
      bus.entrada = 64'({$urandom, $urandom});
      bus.resultado_pronto = ($urandom_range(0, 3) != 0);
      ciclo();
    end
    // asynchronous reset between edges while full
    bus.modo = 1'b0; bus.M = 2'd3; bus.entrada_valida = 4'b1000; set_word(3, 16'h5A5A); bus.resultado_pronto = 1'b0;
    ciclo();
    ciclo();
    chk("r36_pre", 32'(bus.resultado_valido), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r36_valido", 32'(bus.resultado_valido), 32'd0);
    chk("r36_res", 32'(bus.resultado), 32'h0);
    chk("r36_pronta", 32'(bus.entrada_pronta), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    bus.modo = 1'b1; bus.entrada_valida = 4'b0110; bus.resultado_pronto = 1'b1;
    ciclo();
    chk("r30_first", 32'(bus.canal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.entrada_valida = 4'($urandom);
      bus.entrada = 64'({$urandom, $urandom});
      ciclo();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
